// File: rtl/stencil_out_collector.sv
// Collects the raw stencil stream, drops warm-up/border samples and queues valid pixels.
// Latency: a kept sample shows on out_valid one cycle after it is consumed. Backpressure: out_ready stalls only the FIFO; upstream never stalls, so a push into a full FIFO is dropped and overflow is flagged.
module stencil_out_collector #(
  parameter int WIDTH   = 16,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int SKIP    = 4,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             frame_done,
  output logic             overflow,
  output logic             busy
);

  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, COLLECT, DRAIN} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [LW-1:0]   wait_cnt;
  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     cnt_nxt;
  logic            col_end;
  logic            row_end;
  logic            last_sample;
  logic            in_window;
  logic            empty;
  logic            full;
  logic            want_push;
  logic            push;
  logic            pop;
  logic            drop;

  always_comb begin
    col_end     = (col == CW'(IMG_W - 1));
    row_end     = (row == RW'(IMG_H - 1));
    last_sample = (state == COLLECT) && col_end && row_end;
    in_window   = (col >= CW'(SKIP)) && (row >= RW'(SKIP));
    empty       = (count == '0);
    full        = (count == (AW+1)'(DEPTH));
    pop         = !empty && out_ready;
    want_push   = (state == COLLECT) && in_window;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push        = want_push && (!full || pop);
    drop        = want_push && full && !pop;
    cnt_nxt     = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr][WIDTH-1:0];
  assign out_last  = mem[rd_ptr][WIDTH] && out_valid;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {last_sample, in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      wait_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      count <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      // High exactly during the DRAIN cycle that finds the FIFO empty.
      frame_done <= (last_sample || (state == DRAIN && !empty)) && (cnt_nxt == '0);
      case (state)
        IDLE: begin
          if (start) begin
            col      <= '0;
            row      <= '0;
            wait_cnt <= '0;
            overflow <= 1'b0;
            state    <= (LATENCY == 0) ? COLLECT : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == LW'(LAT_M1)) state <= COLLECT;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        COLLECT: begin
          if (col_end) begin
            col <= '0;
            if (row_end) state <= DRAIN;
            else row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: begin
          if (empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
